// File: rtl/fft_buf_pkg.sv
// Shared definitions for the FFT SDPRAM input buffer: bank states,
// writer FSM states and the bit-reversal helper used for addressing.
package fft_buf_pkg;

   localparam logic [1:0] BK_EMPTY   = 2'd0;
   localparam logic [1:0] BK_FILLING = 2'd1;
   localparam logic [1:0] BK_FULL    = 2'd2;
   localparam logic [1:0] BK_READING = 2'd3;

   localparam int BITREV_MAX = 10;

   typedef enum logic [1:0] {
      WR_IDLE  = 2'd0,
      WR_WRITE = 2'd1,
      WR_PAD   = 2'd2,
      WR_CLOSE = 2'd3
   } wr_state_t;

   // Reverses the low 'width' bits of count; bits above width come back as zero.
   function automatic logic [BITREV_MAX-1:0] bitrev(input logic [BITREV_MAX-1:0] count,
                                                    input int width);
      logic [BITREV_MAX-1:0] result;
      logic [3:0]            src;
      result = '0;
      for (int i = 0; i < BITREV_MAX; i++) begin
         src = 4'(width - 1 - i);
         if (i < width) result[i] = count[src];
      end
      return result;
   endfunction

endpackage

// File: rtl/ipsxe_fft_bank_tracker.sv
// Tracks the EMPTY/FILLING/FULL/READING state of both ping-pong banks and
// which bank is offered next to the read-side engine.
module ipsxe_fft_bank_tracker
   import fft_buf_pkg::*;
(
   input  logic wr_clk,
   input  logic asyn_rst,
   input  logic set_filling,
   input  logic set_full,
   input  logic wr_bank,
   input  logic frm_ack,
   input  logic rd_done,
   input  logic rd_done_bank,
   output logic wr_bank_empty,
   output logic frm_valid,
   output logic frm_bank,
   output logic err_proto
);

   logic [1:0] bank0_state;
   logic [1:0] bank1_state;
   logic       rd_bank;
   logic [1:0] rd_state;
   logic [1:0] wr_state;
   logic [1:0] done_state;
   logic       ack_take;

   assign rd_state      = rd_bank      ? bank1_state : bank0_state;
   assign wr_state      = wr_bank      ? bank1_state : bank0_state;
   assign done_state    = rd_done_bank ? bank1_state : bank0_state;
   assign frm_valid     = (rd_state == BK_FULL);
   assign frm_bank      = rd_bank;
   assign wr_bank_empty = (wr_state == BK_EMPTY);
   assign ack_take      = frm_ack & frm_valid;

   // Each legal event requires a distinct current state, so at most one applies per bank.
   function automatic logic [1:0] bank_next(input logic [1:0] cur, input logic idx);
      logic [1:0] nxt;
      nxt = cur;
      if (set_filling && (wr_bank == idx) && (cur == BK_EMPTY))
         nxt = BK_FILLING;
      else if (set_full && (wr_bank == idx) && (cur == BK_FILLING))
         nxt = BK_FULL;
      else if (ack_take && (rd_bank == idx))
         nxt = BK_READING;
      else if (rd_done && (rd_done_bank == idx) && (cur == BK_READING))
         nxt = BK_EMPTY;
      return nxt;
   endfunction

   // Bank state registers, offer pointer and the protocol-error pulse.
   always_ff @(posedge wr_clk or posedge asyn_rst) begin
      if (asyn_rst) begin
         bank0_state <= BK_EMPTY;
         bank1_state <= BK_EMPTY;
         rd_bank     <= 1'b0;
         err_proto   <= 1'b0;
      end else begin
         bank0_state <= bank_next(bank0_state, 1'b0);
         bank1_state <= bank_next(bank1_state, 1'b1);
         err_proto   <= rd_done && (done_state != BK_READING);
         if (ack_take) rd_bank <= ~rd_bank;
      end
   end

endmodule

// File: rtl/ipsxe_fft_sdpram_frame_writer.sv
// Write side of the FFT input buffer: accepts a sample stream, writes it into
// alternating RAM banks, zero-pads short frames and hands full banks to the reader.
module ipsxe_fft_sdpram_frame_writer
   import fft_buf_pkg::*;
#(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int BIT_REV    = 0
)(
   input  logic                  wr_clk,
   input  logic                  asyn_rst,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_valid,
   input  logic                  s_last,
   output logic                  s_ready,
   output logic                  ram_wr_en,
   output logic [ADDR_WIDTH-1:0] ram_wr_addr,
   output logic [DATA_WIDTH-1:0] ram_wr_data,
   output logic                  frm_valid,
   output logic                  frm_bank,
   input  logic                  frm_ack,
   input  logic                  rd_done,
   input  logic                  rd_done_bank,
   output logic                  err_short,
   output logic                  err_long,
   output logic                  err_proto
);

   localparam int AW1 = ADDR_WIDTH - 1;

   wr_state_t                 state;
   logic [AW1-1:0]            count;
   logic                      wr_bank;
   logic                      run;
   logic                      wr_bank_empty;
   logic                      handshake;
   logic                      set_filling;
   logic                      set_full;
   logic                      last_slot;
   logic [BITREV_MAX-1:0]     count_ext;
   logic [BITREV_MAX-1:0]     count_rev;
   logic [AW1-1:0]            in_bank_addr;

   // run keeps s_ready low while reset is held, so every output reads 0 during reset.
   assign s_ready     = run & ((state == WR_WRITE) | ((state == WR_IDLE) & wr_bank_empty));
   assign handshake   = s_valid & s_ready;
   assign set_filling = handshake & (state == WR_IDLE);
   assign set_full    = (state == WR_CLOSE);
   assign last_slot   = &count;

   // In-bank address: the sample counter, optionally bit-reversed.
   always_comb begin
      count_ext    = BITREV_MAX'(count);
      count_rev    = bitrev(count_ext, AW1);
      in_bank_addr = (BIT_REV != 0) ? count_rev[AW1-1:0] : count;
   end

   ipsxe_fft_bank_tracker u_tracker (
      .wr_clk        (wr_clk),
      .asyn_rst      (asyn_rst),
      .set_filling   (set_filling),
      .set_full      (set_full),
      .wr_bank       (wr_bank),
      .frm_ack       (frm_ack),
      .rd_done       (rd_done),
      .rd_done_bank  (rd_done_bank),
      .wr_bank_empty (wr_bank_empty),
      .frm_valid     (frm_valid),
      .frm_bank      (frm_bank),
      .err_proto     (err_proto)
   );

   // Writer FSM with registered RAM write port and error pulses.
   always_ff @(posedge wr_clk or posedge asyn_rst) begin
      if (asyn_rst) begin
         state       <= WR_IDLE;
         count       <= '0;
         wr_bank     <= 1'b0;
         run         <= 1'b0;
         ram_wr_en   <= 1'b0;
         ram_wr_addr <= '0;
         ram_wr_data <= '0;
         err_short   <= 1'b0;
         err_long    <= 1'b0;
      end else begin
         run       <= 1'b1;
         ram_wr_en <= 1'b0;
         err_short <= 1'b0;
         err_long  <= 1'b0;
         case (state)
            WR_IDLE, WR_WRITE: begin
               if (handshake) begin
                  ram_wr_en   <= 1'b1;
                  ram_wr_addr <= {wr_bank, in_bank_addr};
                  ram_wr_data <= s_data;
                  count       <= count + 1'b1;
                  if (last_slot) begin
                     err_long <= ~s_last;
                     state    <= WR_CLOSE;
                  end else if (s_last) begin
                     err_short <= 1'b1;
                     state     <= WR_PAD;
                  end else begin
                     state <= WR_WRITE;
                  end
               end
            end
            WR_PAD: begin
               ram_wr_en   <= 1'b1;
               ram_wr_addr <= {wr_bank, in_bank_addr};
               ram_wr_data <= '0;
               count       <= count + 1'b1;
               if (last_slot) state <= WR_CLOSE;
            end
            WR_CLOSE: begin
               wr_bank <= ~wr_bank;
               count   <= '0;
               state   <= WR_IDLE;
            end
            default: state <= WR_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ipsxe_fft_sdpram_frame_writer.sv
// Bench for the frame writer: a natural-order and a bit-reversed instance share
// one stimulus stream and are checked against a frame-level reference model.
module tb_ipsxe_fft_sdpram_frame_writer;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int N  = 16;

   logic          wr_clk = 1'b0;
   logic          asyn_rst = 1'b1;
   logic [DW-1:0] s_data = '0;
   logic          s_valid = 1'b0;
   logic          s_last = 1'b0;
   logic          frm_ack = 1'b0;
   logic          rd_done = 1'b0;
   logic          rd_done_bank = 1'b0;

   logic          s_ready0, ram_wr_en0, frm_valid0, frm_bank0, err_short0, err_long0, err_proto0;
   logic [AW-1:0] ram_wr_addr0;
   logic [DW-1:0] ram_wr_data0;
   logic          s_ready1, ram_wr_en1, frm_valid1, frm_bank1, err_short1, err_long1, err_proto1;
   logic [AW-1:0] ram_wr_addr1;
   logic [DW-1:0] ram_wr_data1;

   typedef struct {
      logic [AW-1:0] a_nat;
      logic [AW-1:0] a_rev;
      logic [DW-1:0] data;
      bit            fend;
   } wr_t;

   wr_t exp_q[$];
   int  n_checks = 0;
   int  n_fail = 0;
   int  exp_wr_bank = 0;
   int  exp_rd_bank = 0;
   int  frames_done = 0;
   int  reads = 0;
   int  exp_short = 0, exp_long = 0, exp_proto = 0;
   int  obs_short0 = 0, obs_long0 = 0, obs_proto0 = 0;
   int  obs_short1 = 0, obs_long1 = 0, obs_proto1 = 0;
   bit  aborted = 0;

   ipsxe_fft_sdpram_frame_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BIT_REV(0)) dut_nat (
      .wr_clk(wr_clk), .asyn_rst(asyn_rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
      .s_ready(s_ready0), .ram_wr_en(ram_wr_en0), .ram_wr_addr(ram_wr_addr0), .ram_wr_data(ram_wr_data0),
      .frm_valid(frm_valid0), .frm_bank(frm_bank0), .frm_ack(frm_ack), .rd_done(rd_done),
      .rd_done_bank(rd_done_bank), .err_short(err_short0), .err_long(err_long0), .err_proto(err_proto0)
   );

   ipsxe_fft_sdpram_frame_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BIT_REV(1)) dut_rev (
      .wr_clk(wr_clk), .asyn_rst(asyn_rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
      .s_ready(s_ready1), .ram_wr_en(ram_wr_en1), .ram_wr_addr(ram_wr_addr1), .ram_wr_data(ram_wr_data1),
      .frm_valid(frm_valid1), .frm_bank(frm_bank1), .frm_ack(frm_ack), .rd_done(rd_done),
      .rd_done_bank(rd_done_bank), .err_short(err_short1), .err_long(err_long1), .err_proto(err_proto1)
   );

   // Free-running 100 MHz clock.
   always #5 wr_clk = ~wr_clk;

   // Hard stop in case something hangs beyond every bounded wait.
   initial begin
      #700000;
      $display("[TB] FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   function automatic int brev4(input int v);
      int r = 0;
      for (int i = 0; i < 4; i++) if (v[i]) r |= 1 << (3 - i);
      return r;
   endfunction

   // Write scoreboard and error-pulse counters, sampled mid-cycle.
   always @(negedge wr_clk) begin
      wr_t e;
      if (ram_wr_en0 || ram_wr_en1) begin
         checkOutput("wr_en_both", {ram_wr_en0, ram_wr_en1}, 2'b11);
         checkOutput("write_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checkOutput("wr_addr_nat", ram_wr_addr0, e.a_nat);
            checkOutput("wr_addr_rev", ram_wr_addr1, e.a_rev);
            checkOutput("wr_data", {ram_wr_data0, ram_wr_data1}, {e.data, e.data});
            if (e.fend) frames_done++;
         end
      end
      obs_short0 += int'(err_short0); obs_long0 += int'(err_long0); obs_proto0 += int'(err_proto0);
      obs_short1 += int'(err_short1); obs_long1 += int'(err_long1); obs_proto1 += int'(err_proto1);
   end

   task automatic checkResetOutputs(input string tag);
      checkOutput(tag, {ram_wr_en0, ram_wr_addr0, ram_wr_data0, s_ready0, frm_valid0, frm_bank0,
                        err_short0, err_long0, err_proto0}, 64'd0);
      checkOutput(tag, {ram_wr_en1, ram_wr_addr1, ram_wr_data1, s_ready1, frm_valid1, frm_bank1,
                        err_short1, err_long1, err_proto1}, 64'd0);
   endtask

   task automatic applyReset();
      asyn_rst = 1'b1;
      repeat (3) @(negedge wr_clk);
      checkResetOutputs("reset_outputs");
      asyn_rst = 1'b0;
      exp_q.delete();
      exp_wr_bank = 0; exp_rd_bank = 0; frames_done = 0; reads = 0;
      repeat (2) @(negedge wr_clk);
      checkOutput("ready_after_reset", {s_ready0, s_ready1}, 2'b11);
      checkOutput("frm_valid_after_reset", {frm_valid0, frm_valid1}, 2'b00);
   endtask

   // One sample; called at a negedge, returns at the negedge after its handshake.
   task automatic applyStimulus(input logic [DW-1:0] data, input logic last);
      int w = 0;
      if (aborted) return;
      s_valid = 1'b1; s_data = data; s_last = last;
      while (!s_ready0 && w < 400) begin @(negedge wr_clk); w++; end
      if (!s_ready0) begin
         checkOutput("ready_timeout", s_ready0, 1);
         aborted = 1; s_valid = 1'b0; s_last = 1'b0;
         return;
      end
      @(negedge wr_clk);
      s_valid = 1'b0; s_last = 1'b0;
   endtask

   // Frame-level model: samples then zero pad up to N, in the next bank of the alternation.
   task automatic sendFrame(input int len, input bit last_flag, input bit seq, input int gap_max);
      logic [DW-1:0] d [N];
      int bank = exp_wr_bank;
      for (int j = 0; j < N; j++) begin
         d[j] = (j < len) ? (seq ? DW'(j) : DW'($urandom)) : '0;
         exp_q.push_back('{a_nat: AW'(bank * N + j), a_rev: AW'(bank * N + brev4(j)),
                           data: d[j], fend: (j == N - 1)});
      end
      exp_wr_bank ^= 1;
      if (len < N) exp_short++;
      else if (!last_flag) exp_long++;
      for (int j = 0; j < len; j++) begin
         if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge wr_clk);
         applyStimulus(d[j], (j == len - 1) && (len < N || last_flag));
      end
   endtask

   task automatic pulseAck();
      frm_ack = 1'b1; @(negedge wr_clk); frm_ack = 1'b0;
   endtask

   task automatic pulseDone(input logic bank);
      rd_done = 1'b1; rd_done_bank = bank; @(negedge wr_clk); rd_done = 1'b0;
   endtask

   // Randomised reader: waits for an offer, acks it, later releases the bank.
   task automatic readerLoop(input int nframes);
      for (int r = 0; r < nframes && !aborted; r++) begin
         int w = 0;
         while (!frm_valid0 && w < 3000) begin @(negedge wr_clk); w++; end
         checkOutput("reader_offer_seen", frm_valid0, 1);
         if (!frm_valid0) begin aborted = 1; break; end
         repeat ($urandom_range(0, 4)) @(negedge wr_clk);
         checkOutput("reader_frm_bank", {frm_bank0, frm_bank1}, {2{exp_rd_bank[0]}});
         checkOutput("reader_frame_written", frames_done > reads, 1);
         pulseAck();
         reads++;
         repeat ($urandom_range(0, 6)) @(negedge wr_clk);
         pulseDone(exp_rd_bank[0]);
         exp_rd_bank ^= 1;
      end
   endtask

   task automatic writerLoop(input int nframes);
      for (int f = 0; f < nframes && !aborted; f++) begin
         case ($urandom_range(0, 2))
            0:       sendFrame(N, 1, 0, 3);
            1:       sendFrame(N, 0, 0, 3);
            default: sendFrame($urandom_range(1, N - 1), 1, 0, 3);
         endcase
      end
   endtask

   initial begin
      applyReset();

      // rd_done on an EMPTY bank: protocol error only
      exp_proto++;
      pulseDone(1'b1);
      checkOutput("err_proto_pulse", {err_proto0, err_proto1}, 2'b11);
      checkOutput("proto_no_offer", {frm_valid0, frm_valid1}, 2'b00);
      checkOutput("proto_ready_kept", {s_ready0, s_ready1}, 2'b11);
      @(negedge wr_clk);
      checkOutput("err_proto_one_cycle", {err_proto0, err_proto1}, 2'b00);

      // Frame 1: 0..15, offer two cycles after the last handshake
      sendFrame(N, 1, 1, 0);
      checkOutput("frm_valid_not_early", {frm_valid0, frm_valid1}, 2'b00);
      @(negedge wr_clk);
      checkOutput("frm_valid_after_frame", {frm_valid0, frm_valid1}, 2'b11);
      checkOutput("frm_bank_first", {frm_bank0, frm_bank1}, 2'b00);

      // Frame 2 fills bank1; frame 3 must be back-pressured
      sendFrame(N, 1, 1, 0);
      s_valid = 1'b1; s_data = 32'hDEAD_BEEF;
      for (int i = 0; i < 4; i++) begin
         @(negedge wr_clk);
         checkOutput("backpressure_ready", {s_ready0, s_ready1}, 2'b00);
      end
      s_valid = 1'b0;
      checkOutput("offer_bank0", {frm_valid0, frm_bank0, frm_valid1, frm_bank1}, 4'b1010);
      pulseAck();
      checkOutput("offer_bank1_after_ack", {frm_valid0, frm_bank0, frm_valid1, frm_bank1}, 4'b1111);
      checkOutput("ready_while_reading", {s_ready0, s_ready1}, 2'b00);
      pulseDone(1'b0);
      checkOutput("ready_after_release", {s_ready0, s_ready1}, 2'b11);
      sendFrame(N, 1, 1, 0);
      @(negedge wr_clk);
      checkOutput("offer_bank1_again", {frm_valid0, frm_bank0, frm_valid1, frm_bank1}, 4'b1111);
      pulseAck();
      checkOutput("offer_bank0_frame3", {frm_valid0, frm_bank0, frm_valid1, frm_bank1}, 4'b1010);
      frm_ack = 1'b1;
      pulseDone(1'b1);
      frm_ack = 1'b0;
      checkOutput("ack_and_done_together", {frm_valid0, frm_valid1}, 2'b00);
      checkOutput("ready_bank1_freed", {s_ready0, s_ready1}, 2'b11);
      pulseDone(1'b0);

      // Short frame: last on sample 5, pad to 15, then a long frame in bank1
      applyReset();
      sendFrame(5, 1, 0, 0);
      checkOutput("err_short_pulse", {err_short0, err_long0, err_short1, err_long1}, 4'b1010);
      for (int i = 0; i < 11; i++) begin
         @(negedge wr_clk);
         checkOutput("no_offer_during_pad", {frm_valid0, frm_valid1}, 2'b00);
      end
      @(negedge wr_clk);
      checkOutput("offer_after_pad", {frm_valid0, frm_bank0, frm_valid1, frm_bank1}, 4'b1010);
      sendFrame(N, 0, 0, 0);
      checkOutput("err_long_pulse", {err_short0, err_long0, err_short1, err_long1}, 4'b0101);
      @(negedge wr_clk);
      pulseAck();
      checkOutput("long_frame_closed", {frm_valid0, frm_bank0, frm_valid1, frm_bank1}, 4'b1111);

      // Reset in the middle of a frame
      applyReset();
      for (int j = 0; j < 7; j++) begin
         logic [DW-1:0] v = DW'($urandom);
         exp_q.push_back('{a_nat: AW'(j), a_rev: AW'(brev4(j)), data: v, fend: 0});
         applyStimulus(v, 1'b0);
      end
      @(negedge wr_clk);
      #2 asyn_rst = 1'b1;
      #1 checkResetOutputs("midframe_reset_outputs");
      @(negedge wr_clk);
      checkOutput("midframe_writes_done", exp_q.size(), 0);
      asyn_rst = 1'b0;
      exp_q.delete();
      exp_wr_bank = 0; exp_rd_bank = 0; frames_done = 0; reads = 0;
      repeat (2) @(negedge wr_clk);
      checkOutput("ready_after_midframe_reset", {s_ready0, s_ready1}, 2'b11);
      sendFrame(N, 1, 0, 0);
      @(negedge wr_clk);
      checkOutput("offer_after_midframe_reset", {frm_valid0, frm_bank0, frm_valid1, frm_bank1}, 4'b1010);

      // Random traffic against a randomly paced reader
      fork
         writerLoop(12);
         readerLoop(13);
      join
      repeat (30) @(negedge wr_clk);
      checkOutput("queue_drained", exp_q.size(), 0);
      checkOutput("idle_no_offer", {frm_valid0, frm_valid1}, 2'b00);
      checkOutput("err_short_count", {32'(obs_short0), 32'(obs_short1)}, {32'(exp_short), 32'(exp_short)});
      checkOutput("err_long_count", {32'(obs_long0), 32'(obs_long1)}, {32'(exp_long), 32'(exp_long)});
      checkOutput("err_proto_count", {32'(obs_proto0), 32'(obs_proto1)}, {32'(exp_proto), 32'(exp_proto)});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
